// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - UART transmit frame sequencer with two-port round-robin arbiter
// Serialises start, LSB-first data, optional parity and stop bits, one bit per baud tick.
module uart_tx_scheduler #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 system_clock,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 req0_valid,
   input  logic [DATA_BITS-1:0] req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [DATA_BITS-1:0] req1_data,
   output logic                 req1_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 grant_id
);
   localparam int            CW        = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic          ODD       = 1'(PARITY_ODD);

   typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_t;

   state_t               state;
   state_t               state_next;
   logic                 tx_next;
   logic [CW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 parity_bit;
   logic                 prefer;
   logic                 winner;
   logic                 idle;
   logic                 xfer;
   logic [DATA_BITS-1:0] load_data;

   // prefer names the requester that wins a tie; it flips away from each winner.
   assign idle       = (state == IDLE);
   assign busy       = !idle;
   assign winner     = (req0_valid && req1_valid) ? prefer : !req0_valid;
   assign req0_ready = idle && req0_valid && !winner;
   assign req1_ready = idle && req1_valid && winner;
   assign xfer       = req0_ready || req1_ready;
   assign load_data  = winner ? req1_data : req0_data;

   always_ff @(posedge system_clock) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      tx_next    = tx;
      case (state)
         IDLE:   if (xfer) state_next = ALIGN;
         ALIGN:  if (baud_tick) begin
                    state_next = START;
                    tx_next    = 1'b0;
                 end
         START:  if (baud_tick) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                 end
         DATA:   if (baud_tick) begin
                    if (bit_cnt != LAST_BIT) begin
                       tx_next = shift[0];
                    end else if (PARITY_EN != 0) begin
                       state_next = PARITY;
                       tx_next    = parity_bit;
                    end else begin
                       state_next = STOP;
                       tx_next    = 1'b1;
                    end
                 end
         PARITY: if (baud_tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                 end
         STOP:   if (baud_tick && stop_cnt == LAST_STOP) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // shift[0] always holds the next data bit to drive once START has begun.
   always_ff @(posedge system_clock) begin
      if (rst) begin
         tx         <= 1'b1;
         grant_id   <= 1'b0;
         prefer     <= 1'b0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shift      <= '0;
         parity_bit <= 1'b0;
      end else begin
         tx <= tx_next;
         if (xfer) begin
            grant_id   <= winner;
            prefer     <= !winner;
            shift      <= load_data;
            parity_bit <= (^load_data) ^ ODD;
            stop_cnt   <= 1'b0;
         end
         if (baud_tick) begin
            case (state)
               START: begin
                  bit_cnt <= '0;
                  shift   <= shift >> 1;
               end
               DATA: if (bit_cnt != LAST_BIT) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  shift   <= shift >> 1;
               end
               STOP: stop_cnt <= stop_cnt + 1'b1;
               default: ;
            endcase
         end
      end
   end
endmodule
